// File: rtl/fp_execute_stage3_pkg.sv
// Shared types for the floating point execute pipeline.
// Provides lane count, scalar/thread/subcycle/mask types, the pipeline
// selector used by writeback rollback, the decoded instruction struct, and
// the add-path rounding helper used by stage 3.
package fp_execute_stage3_pkg;

  localparam int VECTOR_LANES = 16;

  typedef logic [31:0]             scalar_t;
  typedef logic [1:0]              thread_idx_t;
  typedef logic [3:0]              subcycle_t;
  typedef logic [VECTOR_LANES-1:0] vector_mask_t;

  typedef enum logic [1:0] {
    PIPE_MEM         = 2'd0,
    PIPE_INT_ARITH   = 2'd1,
    PIPE_FLOAT_ARITH = 2'd2
  } pipeline_sel_t;

  typedef struct packed {
    logic [5:0] alu_op;
    logic [4:0] dest_reg;
    logic       dest_is_vector;
    logic       has_dest;
  } decoded_instruction_t;

  typedef struct packed {
    logic    carry;
    scalar_t sig;
  } add_result_t;

  // Add or subtract the aligned significands and round to nearest even.
  // On subtract the shifted-out bits of the smaller operand are borrowed
  // from the integer part; f is the fraction left behind (8 - grs), which
  // then acts as the guard/round/sticky of the result.
  function automatic add_result_t add_round(input scalar_t le, input scalar_t se,
                                            input logic sub, input logic g,
                                            input logic r, input logic s);
    add_result_t res;
    logic [32:0] raw;
    scalar_t     diff;
    logic [2:0]  f;
    logic        up;
    if (!sub) begin
      raw       = {1'b0, le} + {1'b0, se};
      up        = g & (r | s | raw[0]);
      raw       = raw + {32'd0, up};
      res.carry = raw[32];
      res.sig   = raw[31:0];
    end else begin
      diff      = le - se - {31'd0, (g | r | s)};
      f         = ~{g, r, s} + 3'd1;
      up        = f[2] & (f[1] | f[0] | diff[0]);
      res.carry = 1'b0;
      res.sig   = diff + {31'd0, up};
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_execute_stage3_lzc.sv
// fp_leading_zero_counter: leading zero count of a 32-bit value, counted
// from bit 31. A zero input gives 32.
//   value    in  32  operand
//   lz_count out 6   number of leading zeros (0..32)
module fp_leading_zero_counter (
  input  logic [31:0] value,
  output logic [5:0]  lz_count
);

  // Higher set bits overwrite lower ones, so the last hit is the MSB.
  always_comb begin
    lz_count = 6'd32;
    for (int i = 0; i < 32; i++)
      if (value[i]) lz_count = 6'(31 - i);
  end

endmodule

// File: rtl/fp_execute_stage3.sv
// fp_execute_stage3: third floating point execute stage.
// Add path: sums/differences aligned significands, rounds to nearest even,
// and counts leading zeros of the rounded result for the stage 4 normalizer.
// Multiply/ftoi fields and control are registered straight through.
// Ports:
//   clk, reset                 clock, async active-high reset (valid only)
//   wb_rollback_*              rollback request; squashes matching memory-pipe thread
//   fx2_*                      stage 2 control and per-lane datapath inputs
//   fx3_*                      registered stage 3 outputs to stage 4
module fp_execute_stage3
  import fp_execute_stage3_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wb_rollback_en,
  input  thread_idx_t                            wb_rollback_thread_idx,
  input  pipeline_sel_t                          wb_rollback_pipeline,
  input  logic                                   fx2_instruction_valid,
  input  decoded_instruction_t                   fx2_instruction,
  input  vector_mask_t                           fx2_mask_value,
  input  thread_idx_t                            fx2_thread_idx,
  input  subcycle_t                              fx2_subcycle,
  input  logic [VECTOR_LANES-1:0]                fx2_result_is_inf,
  input  logic [VECTOR_LANES-1:0]                fx2_result_is_nan,
  input  logic [VECTOR_LANES-1:0][5:0]           fx2_ftoi_lshift,
  input  logic [VECTOR_LANES-1:0][31:0]          fx2_significand_le,
  input  logic [VECTOR_LANES-1:0][31:0]          fx2_significand_se,
  input  logic [VECTOR_LANES-1:0]                fx2_logical_subtract,
  input  logic [VECTOR_LANES-1:0]                fx2_add_result_sign,
  input  logic [VECTOR_LANES-1:0][7:0]           fx2_add_exponent,
  input  logic [VECTOR_LANES-1:0]                fx2_guard,
  input  logic [VECTOR_LANES-1:0]                fx2_round,
  input  logic [VECTOR_LANES-1:0]                fx2_sticky,
  input  logic [VECTOR_LANES-1:0][63:0]          fx2_significand_product,
  input  logic [VECTOR_LANES-1:0][7:0]           fx2_mul_exponent,
  input  logic [VECTOR_LANES-1:0]                fx2_mul_sign,
  output logic                                   fx3_instruction_valid,
  output decoded_instruction_t                   fx3_instruction,
  output vector_mask_t                           fx3_mask_value,
  output thread_idx_t                            fx3_thread_idx,
  output subcycle_t                              fx3_subcycle,
  output logic [VECTOR_LANES-1:0]                fx3_result_is_inf,
  output logic [VECTOR_LANES-1:0]                fx3_result_is_nan,
  output logic [VECTOR_LANES-1:0][5:0]           fx3_ftoi_lshift,
  output logic [VECTOR_LANES-1:0][31:0]          fx3_add_significand,
  output logic [VECTOR_LANES-1:0]                fx3_add_carry,
  output logic [VECTOR_LANES-1:0][5:0]           fx3_add_lzc,
  output logic [VECTOR_LANES-1:0][7:0]           fx3_add_exponent,
  output logic [VECTOR_LANES-1:0]                fx3_add_result_sign,
  output logic [VECTOR_LANES-1:0]                fx3_logical_subtract,
  output logic [VECTOR_LANES-1:0][63:0]          fx3_significand_product,
  output logic [VECTOR_LANES-1:0][7:0]           fx3_mul_exponent,
  output logic [VECTOR_LANES-1:0]                fx3_mul_sign
);

  logic squash;
  logic [VECTOR_LANES-1:0][31:0] sum_sig;
  logic [VECTOR_LANES-1:0]       sum_carry;
  logic [VECTOR_LANES-1:0][5:0]  sum_lzc;

  // Rollback only kills memory-pipe ops of the rolled-back thread.
  assign squash = wb_rollback_en
               && (wb_rollback_thread_idx == fx2_thread_idx)
               && (wb_rollback_pipeline == PIPE_MEM);

  // Every lane computes every cycle; stage 4 applies the mask.
  for (genvar lane = 0; lane < VECTOR_LANES; lane++) begin : g_lane
    add_result_t res;
    assign res = add_round(fx2_significand_le[lane], fx2_significand_se[lane],
                           fx2_logical_subtract[lane], fx2_guard[lane],
                           fx2_round[lane], fx2_sticky[lane]);
    assign sum_sig[lane]   = res.sig;
    assign sum_carry[lane] = res.carry;

    fp_leading_zero_counter u_lzc (
      .value    (res.sig),
      .lz_count (sum_lzc[lane])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fx3_instruction_valid <= 1'b0;
    else       fx3_instruction_valid <= fx2_instruction_valid && !squash;
  end

  // Datapath is not reset; consumers qualify it with valid.
  always_ff @(posedge clk) begin
    fx3_instruction         <= fx2_instruction;
    fx3_mask_value          <= fx2_mask_value;
    fx3_thread_idx          <= fx2_thread_idx;
    fx3_subcycle            <= fx2_subcycle;
    fx3_result_is_inf       <= fx2_result_is_inf;
    fx3_result_is_nan       <= fx2_result_is_nan;
    fx3_ftoi_lshift         <= fx2_ftoi_lshift;
    fx3_add_significand     <= sum_sig;
    fx3_add_carry           <= sum_carry;
    fx3_add_lzc             <= sum_lzc;
    fx3_add_exponent        <= fx2_add_exponent;
    fx3_add_result_sign     <= fx2_add_result_sign;
    fx3_logical_subtract    <= fx2_logical_subtract;
    fx3_significand_product <= fx2_significand_product;
    fx3_mul_exponent        <= fx2_mul_exponent;
    fx3_mul_sign            <= fx2_mul_sign;
  end

endmodule

// File: tb/tb_fp_execute_stage3.sv
module tb_fp_execute_stage3;
  import fp_execute_stage3_pkg::*;
  localparam int L = VECTOR_LANES;

  logic clk = 1'b0;
  logic reset;
  logic wb_rollback_en;
  thread_idx_t wb_rollback_thread_idx;
  pipeline_sel_t wb_rollback_pipeline;
  logic fx2_instruction_valid;
  decoded_instruction_t fx2_instruction;
  vector_mask_t fx2_mask_value;
  thread_idx_t fx2_thread_idx;
  subcycle_t fx2_subcycle;
  logic [L-1:0] fx2_result_is_inf, fx2_result_is_nan;
  logic [L-1:0][5:0] fx2_ftoi_lshift;
  logic [L-1:0][31:0] fx2_significand_le, fx2_significand_se;
  logic [L-1:0] fx2_logical_subtract, fx2_add_result_sign;
  logic [L-1:0][7:0] fx2_add_exponent;
  logic [L-1:0] fx2_guard, fx2_round, fx2_sticky;
  logic [L-1:0][63:0] fx2_significand_product;
  logic [L-1:0][7:0] fx2_mul_exponent;
  logic [L-1:0] fx2_mul_sign;
  logic fx3_instruction_valid;
  decoded_instruction_t fx3_instruction;
  vector_mask_t fx3_mask_value;
  thread_idx_t fx3_thread_idx;
  subcycle_t fx3_subcycle;
  logic [L-1:0] fx3_result_is_inf, fx3_result_is_nan;
  logic [L-1:0][5:0] fx3_ftoi_lshift;
  logic [L-1:0][31:0] fx3_add_significand;
  logic [L-1:0] fx3_add_carry;
  logic [L-1:0][5:0] fx3_add_lzc;
  logic [L-1:0][7:0] fx3_add_exponent;
  logic [L-1:0] fx3_add_result_sign, fx3_logical_subtract;
  logic [L-1:0][63:0] fx3_significand_product;
  logic [L-1:0][7:0] fx3_mul_exponent;
  logic [L-1:0] fx3_mul_sign;

  always #5 clk = ~clk;

  fp_execute_stage3 dut (
    .clk(clk), .reset(reset),
    .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .wb_rollback_pipeline(wb_rollback_pipeline),
    .fx2_instruction_valid(fx2_instruction_valid), .fx2_instruction(fx2_instruction),
    .fx2_mask_value(fx2_mask_value), .fx2_thread_idx(fx2_thread_idx), .fx2_subcycle(fx2_subcycle),
    .fx2_result_is_inf(fx2_result_is_inf), .fx2_result_is_nan(fx2_result_is_nan),
    .fx2_ftoi_lshift(fx2_ftoi_lshift),
    .fx2_significand_le(fx2_significand_le), .fx2_significand_se(fx2_significand_se),
    .fx2_logical_subtract(fx2_logical_subtract), .fx2_add_result_sign(fx2_add_result_sign),
    .fx2_add_exponent(fx2_add_exponent),
    .fx2_guard(fx2_guard), .fx2_round(fx2_round), .fx2_sticky(fx2_sticky),
    .fx2_significand_product(fx2_significand_product), .fx2_mul_exponent(fx2_mul_exponent),
    .fx2_mul_sign(fx2_mul_sign),
    .fx3_instruction_valid(fx3_instruction_valid), .fx3_instruction(fx3_instruction),
    .fx3_mask_value(fx3_mask_value), .fx3_thread_idx(fx3_thread_idx), .fx3_subcycle(fx3_subcycle),
    .fx3_result_is_inf(fx3_result_is_inf), .fx3_result_is_nan(fx3_result_is_nan),
    .fx3_ftoi_lshift(fx3_ftoi_lshift),
    .fx3_add_significand(fx3_add_significand), .fx3_add_carry(fx3_add_carry),
    .fx3_add_lzc(fx3_add_lzc), .fx3_add_exponent(fx3_add_exponent),
    .fx3_add_result_sign(fx3_add_result_sign), .fx3_logical_subtract(fx3_logical_subtract),
    .fx3_significand_product(fx3_significand_product), .fx3_mul_exponent(fx3_mul_exponent),
    .fx3_mul_sign(fx3_mul_sign)
  );

  typedef struct {
    logic                 valid;
    decoded_instruction_t instr;
    vector_mask_t         mask;
    thread_idx_t          tid;
    subcycle_t            sub;
    logic [L-1:0]         inf, nan, lsub, asign, msign, carry;
    logic [L-1:0][5:0]    lshift, lzc;
    logic [L-1:0][31:0]   sig;
    logic [L-1:0][7:0]    aexp, mexp;
    logic [L-1:0][63:0]   prod;
  } op_t;

  int total = 0;
  int bad = 0;
  op_t cur, prev;

  // Exact arithmetic in eighths: value*8 + grs, then round-half-even.
  function automatic void model_lane(input logic [31:0] le, input logic [31:0] se,
                                     input logic sub, input logic g, input logic r,
                                     input logic s, output logic [31:0] sig,
                                     output logic carry, output logic [5:0] lzc);
    longint unsigned exact, q, rem, grs;
    int n;
    grs = {61'd0, g, r, s};
    if (!sub) exact = longint'(le) * 8 + longint'(se) * 8 + grs;
    else      exact = longint'(le) * 8 - (longint'(se) * 8 + grs);
    q = exact >> 3;
    rem = exact & 64'd7;
    if (rem > 4 || (rem == 4 && q[0])) q = q + 1;
    sig = q[31:0];
    carry = sub ? 1'b0 : q[32];
    n = 0;
    while (n < 32 && sig[31-n] == 1'b0) n++;
    lzc = 6'(n);
  endfunction

  function automatic op_t snapshot();
    op_t o;
    o.valid = fx2_instruction_valid && !(wb_rollback_en &&
              wb_rollback_thread_idx == fx2_thread_idx && wb_rollback_pipeline == PIPE_MEM);
    o.instr = fx2_instruction; o.mask = fx2_mask_value;
    o.tid = fx2_thread_idx; o.sub = fx2_subcycle;
    o.inf = fx2_result_is_inf; o.nan = fx2_result_is_nan; o.lshift = fx2_ftoi_lshift;
    o.lsub = fx2_logical_subtract; o.asign = fx2_add_result_sign; o.aexp = fx2_add_exponent;
    o.prod = fx2_significand_product; o.mexp = fx2_mul_exponent; o.msign = fx2_mul_sign;
    for (int i = 0; i < L; i++)
      model_lane(fx2_significand_le[i], fx2_significand_se[i], fx2_logical_subtract[i],
                 fx2_guard[i], fx2_round[i], fx2_sticky[i], o.sig[i], o.carry[i], o.lzc[i]);
    return o;
  endfunction

  task automatic drive_random(input bit all_valid, input bit allow_rb);
    logic [31:0] rnd, rnd2, a, b, c;
    rnd = $urandom; rnd2 = $urandom;
    fx2_instruction_valid = all_valid ? 1'b1 : rnd[0];
    fx2_thread_idx = rnd[2:1];
    fx2_subcycle = rnd[6:3];
    fx2_instruction = rnd[19:7];
    fx2_mask_value = rnd2[15:0];
    wb_rollback_en = allow_rb && rnd[20];
    wb_rollback_thread_idx = rnd[22:21];
    wb_rollback_pipeline = pipeline_sel_t'((rnd[24:23] == 2'd3) ? 2'd0 : rnd[24:23]);
    for (int i = 0; i < L; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      fx2_logical_subtract[i] = c[0];
      fx2_guard[i] = c[1]; fx2_round[i] = c[2]; fx2_sticky[i] = c[3];
      case (c[6:4])
        3'd0:    fx2_significand_le[i] = 32'hFFFFFFFF;
        3'd1:    fx2_significand_le[i] = {9'h001, a[22:0]};
        default: fx2_significand_le[i] = a;
      endcase
      if (c[7] || c[0]) fx2_significand_se[i] = fx2_significand_le[i] >> c[12:8];
      else              fx2_significand_se[i] = b;
      if (c[13]) fx2_significand_se[i] = fx2_significand_le[i];
      // keep subtract non-negative: le >= se + borrow
      if (c[0] && fx2_significand_se[i] == fx2_significand_le[i] && (c[1] | c[2] | c[3])) begin
        if (fx2_significand_le[i] == 32'd0) begin
          fx2_guard[i] = 1'b0; fx2_round[i] = 1'b0; fx2_sticky[i] = 1'b0;
        end else fx2_significand_se[i] = fx2_significand_le[i] - 32'd1;
      end
      fx2_result_is_inf[i] = c[14]; fx2_result_is_nan[i] = c[15];
      fx2_ftoi_lshift[i] = c[21:16]; fx2_add_exponent[i] = c[29:22];
      fx2_add_result_sign[i] = c[30]; fx2_mul_sign[i] = c[31];
      fx2_mul_exponent[i] = b[7:0];
      fx2_significand_product[i] = {a, b ^ c};
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fx2_instruction_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (fx3_instruction_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", fx3_instruction_valid);
    end
    fx2_instruction_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (fx3_instruction_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: got %b want 0", fx3_instruction_valid);
    end
  endtask

  localparam logic [31:0] V_LE  [6] = '{32'h00800000, 32'h00800001, 32'h00800000,
                                        32'h00800000, 32'h00400000, 32'hFFFFFFFF};
  localparam logic [31:0] V_SE  [6] = '{32'h00800000, 32'h0, 32'h0,
                                        32'h00000001, 32'h00400000, 32'hFFFFFFFF};
  localparam logic        V_SUB [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [2:0]  V_GRS [6] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b110};
  localparam logic [31:0] V_SIG [6] = '{32'h01000000, 32'h00800002, 32'h00800000,
                                        32'h007FFFFE, 32'h0, 32'hFFFFFFFF};
  localparam logic        V_CY  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [5:0]  V_LZC [6] = '{6'd7, 6'd8, 6'd8, 6'd9, 6'd32, 6'd0};

  task automatic test_directed();
    logic [31:0] esig; logic ecy; logic [5:0] elzc;
    drive_random(1'b1, 1'b0);
    for (int i = 0; i < L; i++) begin
      fx2_significand_le[i] = (i < 6) ? V_LE[i] : 32'd0;
      fx2_significand_se[i] = (i < 6) ? V_SE[i] : 32'd0;
      fx2_logical_subtract[i] = (i < 6) ? V_SUB[i] : 1'b0;
      {fx2_guard[i], fx2_round[i], fx2_sticky[i]} = (i < 6) ? V_GRS[i] : 3'b000;
    end
    @(posedge clk); #1;
    total++;
    if (fx3_instruction_valid !== 1'b1) begin
      bad++; $display("FAIL directed_valid: got %b want 1", fx3_instruction_valid);
    end
    for (int i = 0; i < L; i++) begin
      esig = (i < 6) ? V_SIG[i] : 32'd0;
      ecy  = (i < 6) ? V_CY[i] : 1'b0;
      elzc = (i < 6) ? V_LZC[i] : 6'd32;
      total++;
      if (fx3_add_significand[i] !== esig || fx3_add_carry[i] !== ecy || fx3_add_lzc[i] !== elzc) begin
        bad++;
        $display("FAIL directed_lane%0d: got sig=%h cy=%b lzc=%0d want sig=%h cy=%b lzc=%0d",
                 i, fx3_add_significand[i], fx3_add_carry[i], fx3_add_lzc[i], esig, ecy, elzc);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive_random(1'b0, 1'b1);
      prev = cur;
      cur = snapshot();
      @(negedge clk);
      if (n > 0) begin
        total++;
        if (fx3_instruction_valid !== prev.valid) begin
          bad++; $display("FAIL rand_valid[%0d]: got %b want %b", n, fx3_instruction_valid, prev.valid);
        end
        total++;
        if (fx3_add_significand !== prev.sig) begin
          bad++; $display("FAIL rand_sig[%0d]: got %h want %h", n, fx3_add_significand, prev.sig);
        end
        total++;
        if (fx3_add_carry !== prev.carry || fx3_add_lzc !== prev.lzc) begin
          bad++; $display("FAIL rand_cy_lzc[%0d]: got %h/%h want %h/%h", n,
                          fx3_add_carry, fx3_add_lzc, prev.carry, prev.lzc);
        end
        total++;
        if ({fx3_instruction, fx3_mask_value, fx3_thread_idx, fx3_subcycle} !==
            {prev.instr, prev.mask, prev.tid, prev.sub}) begin
          bad++; $display("FAIL rand_ctrl[%0d]: got %h want %h", n,
                          {fx3_instruction, fx3_mask_value, fx3_thread_idx, fx3_subcycle},
                          {prev.instr, prev.mask, prev.tid, prev.sub});
        end
        total++;
        if ({fx3_result_is_inf, fx3_result_is_nan, fx3_ftoi_lshift, fx3_add_exponent,
             fx3_add_result_sign, fx3_logical_subtract} !==
            {prev.inf, prev.nan, prev.lshift, prev.aexp, prev.asign, prev.lsub}) begin
          bad++; $display("FAIL rand_addpass[%0d]: flags/exponents differ", n);
        end
        total++;
        if ({fx3_significand_product, fx3_mul_exponent, fx3_mul_sign} !==
            {prev.prod, prev.mexp, prev.msign}) begin
          bad++; $display("FAIL rand_mulpass[%0d]: product/exponent/sign differ", n);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      drive_random(1'b1, 1'b0);
      prev = cur;
      cur = snapshot();
      @(negedge clk);
      if (n > 0) begin
        total++;
        if (fx3_instruction_valid !== 1'b1 || fx3_add_significand !== prev.sig ||
            fx3_significand_product !== prev.prod || fx3_add_lzc !== prev.lzc) begin
          bad++; $display("FAIL b2b[%0d]: valid=%b sig=%h want sig=%h", n,
                          fx3_instruction_valid, fx3_add_significand, prev.sig);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rollback();
    // rb_en, rb_tid, rb_pipe, fx2_tid, fx2_valid, expected valid
    logic        c_en  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    thread_idx_t c_rt  [5] = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd3};
    pipeline_sel_t c_rp[5] = '{PIPE_MEM, PIPE_MEM, PIPE_FLOAT_ARITH, PIPE_MEM, PIPE_MEM};
    thread_idx_t c_ft  [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
    logic        c_fv  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        c_exp [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive_random(1'b1, 1'b0);
      wb_rollback_en = c_en[k]; wb_rollback_thread_idx = c_rt[k];
      wb_rollback_pipeline = c_rp[k]; fx2_thread_idx = c_ft[k];
      fx2_instruction_valid = c_fv[k];
      cur = snapshot();
      @(posedge clk); #1;
      total++;
      if (fx3_instruction_valid !== c_exp[k]) begin
        bad++; $display("FAIL rollback_case%0d: got %b want %b", k, fx3_instruction_valid, c_exp[k]);
      end
      if (c_exp[k]) begin
        total++;
        if (fx3_add_significand !== cur.sig || fx3_significand_product !== cur.prod ||
            fx3_thread_idx !== c_ft[k]) begin
          bad++; $display("FAIL rollback_data%0d: got sig=%h want %h", k, fx3_add_significand, cur.sig);
        end
      end
    end
    wb_rollback_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    drive_random(1'b1, 1'b0);
    @(posedge clk); #1;
    total++;
    if (fx3_instruction_valid !== 1'b1) begin
      bad++; $display("FAIL mid_inflight: got %b want 1", fx3_instruction_valid);
    end
    reset = 1'b1;
    #1;
    total++;
    if (fx3_instruction_valid !== 1'b0) begin
      bad++; $display("FAIL mid_async_clear: got %b want 0", fx3_instruction_valid);
    end
    @(posedge clk); #1;
    total++;
    if (fx3_instruction_valid !== 1'b0) begin
      bad++; $display("FAIL mid_held: got %b want 0", fx3_instruction_valid);
    end
    reset = 1'b0;
    fx2_instruction_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (fx3_instruction_valid !== 1'b0) begin
      bad++; $display("FAIL mid_idle_after: got %b want 0", fx3_instruction_valid);
    end
    drive_random(1'b1, 1'b0);
    cur = snapshot();
    @(posedge clk); #1;
    total++;
    if (fx3_instruction_valid !== 1'b1 || fx3_add_significand !== cur.sig) begin
      bad++; $display("FAIL mid_first_op: valid=%b sig=%h want 1 sig=%h",
                      fx3_instruction_valid, fx3_add_significand, cur.sig);
    end
  endtask

  initial begin
    reset = 1'b1;
    wb_rollback_en = 1'b0; wb_rollback_thread_idx = '0; wb_rollback_pipeline = PIPE_MEM;
    drive_random(1'b0, 1'b0);
    fx2_instruction_valid = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_rollback();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
